gb_oam_dma: RTL and testbench
=============================

# gb_oam_dma

Owns the main 0000–FEFF memory bus and arbitrates it between the CPU and the OAM DMA engine. A CPU write to FF46 triggers a 160-byte copy from `{src,8'h00}` to FE00–FE9F. While the copy runs, the DMA engine has the bus; CPU traffic to FF00–FFFF is forwarded on a separate high port that is never blocked. It sits between `cpu` and the memory/IO map inside `de10boy`, clocked by the CPU clock.

## Interface
Parameters:
- `DMA_LEN`, 160: bytes per transfer.
- `OAM_BASE`, 16'hFE00: destination base.

Ports:
- `Clk`  in  1  CPU clock; all logic rises on this edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_addr`  in  16  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_rd`  in  1  CPU read strobe, one cycle.
- `cpu_wr`  in  1  CPU write strobe, one cycle.
- `cpu_rdata`  out  8  read data, valid the cycle after `cpu_rd`.
- `mem_addr`  out  16  main bus address.
- `mem_wdata`  out  8  main bus write data.
- `mem_we`  out  1  main bus write enable.
- `mem_rdata`  in  8  main bus read data, 1-cycle synchronous latency.
- `hi_addr`  out  16  high-port address (FF00–FFFF), passthrough.
- `hi_wdata`  out  8  high-port write data.
- `hi_rd`  out  1  high-port read strobe.
- `hi_wr`  out  1  high-port write strobe (never asserted for FF46).
- `hi_rdata`  in  8  high-port read data, 1-cycle latency.
- `dma_active`  out  1  transfer in progress.

## Operation
- FF46 register (`dma_src`) is held in this block. A CPU write loads it and starts or restarts a transfer. A CPU read returns it.
- Source mapping: if `cpu_wdata > 8'hDF`, use `cpu_wdata - 8'h20` (FE→DE, E0→C0). The FF46 readback returns the unmapped value.
- States: IDLE, RD, WR.
  - IDLE→RD on FF46 write, with idx=0.
  - RD: drive `mem_addr={src,idx}`, `mem_we=0`; go to WR.
  - WR: drive `mem_addr=OAM_BASE+idx`, `mem_wdata=mem_rdata`, `mem_we=1`. If idx==DMA_LEN-1, go to IDLE; otherwise idx+1 and go to RD.
- idx is 8 bits. It never wraps past 159.
- Restart: an FF46 write in RD or WR reloads src, sets idx=0, and enters RD next cycle. The write in flight in that cycle still completes.
- CPU access to FF00–FFFF (except FF46) goes to the high port combinationally in every state.
- CPU access to 0000–FEFF:
  - In IDLE it drives the main bus; `mem_we=cpu_wr`.
  - In RD/WR it is handled per Configuration.
- `cpu_rdata` mux select is registered from the request cycle: main, high, FF46, or blocked (8'hFF).
- Reset in any state gives IDLE, `dma_src`=8'h00, and all outputs at reset values on the next edge.

## Timing
- Reset values:
  - `mem_addr`=0, `mem_wdata`=0, `mem_we`=0.
  - `hi_*` strobes=0.
  - `dma_active`=0.
  - `cpu_rdata`=8'hFF.
- `dma_active` rises the cycle after the FF46 write. It falls the cycle after the final WR.
- Uncontended transfer: 2·DMA_LEN = 320 cycles.
- CPU read latency is 1 cycle on all paths.

## Configuration
- `GB_DMA_CPU_BLOCK_EN` defined (hardware-accurate):
  - During DMA, main-bus CPU reads return 8'hFF.
  - Main-bus CPU writes are dropped.
  - DMA never stalls.
- Not defined (debug):
  - A CPU main-bus access wins the bus for that cycle.
  - The DMA holds its state (RD or WR) and idx, and resumes next cycle.
  - Transfer length is 320 plus the number of CPU main-bus cycles.

## Structure
- `gb_bus_pkg` holds:
  - the `dma_state_t` enum (IDLE, RD, WR);
  - the constants `DMA_REG_ADDR`=16'hFF46, `HI_BASE`=16'hFF00, `OAM_BASE`;
  - the `rsel_t` read-select enum.
- One sub-module, `dma_sequencer`, owns the state/idx/src and emits the bus request. The top level does decode, arbitration and the `cpu_rdata` mux.

## Test plan
- Preload C100+i = i^8'h5A. Write FF46=8'hC1. Required: `dma_active`=1 next cycle; FE00+i receives i^8'h5A for i=0..159; `dma_active`=0 after 320 cycles.
- With the block macro, read C000 at cycle 10 of the DMA. Required: `cpu_rdata`=8'hFF; `mem_addr` unchanged by the CPU. Read FF80 (hi_rdata=8'h3C). Required: `cpu_rdata`=8'h3C next cycle.
- At idx=50, write FF46=8'hD0. Required: the next `mem_we` after the restart targets FE00 with data from D000; FF46 reads back 8'hD0.
- Write FF46=8'hFE. Required: the first RD drives `mem_addr`=16'hDE00; FF46 reads back 8'hFE.
- Assert `reset` at idx=80. Required: next cycle `dma_active`=0, `mem_we`=0, state IDLE; no further OAM writes.
- Without the macro, issue 5 CPU reads of C000 during DMA. Required: `cpu_rdata` returns the memory value; the transfer completes in 325 cycles with OAM contents correct.

Source files
------------

// File: rtl/gb_bus_pkg.sv
// gb_bus_pkg: shared states, read-select codes and address constants for the OAM DMA bus block.
package gb_bus_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR} dma_state_t;
  typedef enum logic [1:0] {RSEL_MAIN, RSEL_HI, RSEL_REG, RSEL_BLOCK} rsel_t;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] HI_BASE      = 16'hFF00;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  // Pages above DF alias into work RAM (echo region), e.g. FE->DE.
  function automatic logic [7:0] map_src(input logic [7:0] v);
    return (v > 8'hDF) ? v - 8'h20 : v;
  endfunction
endpackage

// File: rtl/dma_sequencer.sv
// dma_sequencer: OAM DMA state/idx/src registers and the DMA bus request (read source, write OAM).
module dma_sequencer import gb_bus_pkg::*; #(
  parameter int          DMA_LEN  = 160,
  parameter logic [15:0] DST_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hold,
  input  logic [7:0]  wr_val,
  input  logic [7:0]  mem_rdata,
  output logic        active,
  output logic        req_we,
  output logic [15:0] req_addr,
  output logic [7:0]  req_wdata,
  output logic [7:0]  reg_val
);
  localparam logic [7:0] LAST = 8'(DMA_LEN - 1);
  dma_state_t state_q, state_d;
  logic [7:0] idx_q, idx_d, src_q, src_d, reg_q, reg_d, data_q, data_d;
  logic       issued_q, issued_d;
  logic [7:0] wr_byte;
  // Read data only arrives the cycle after an issued RD; a held WR falls back to the captured copy.
  assign wr_byte = issued_q ? mem_rdata : data_q;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    src_d    = src_q;
    reg_d    = reg_q;
    issued_d = (state_q == RD) && !hold;
    data_d   = issued_q ? mem_rdata : data_q;
    if (start) begin
      state_d = RD;
      idx_d   = 8'h00;
      src_d   = map_src(wr_val);
      reg_d   = wr_val;
    end else if (!hold) begin
      if (state_q == RD) state_d = WR;
      else if (state_q == WR) begin
        state_d = (idx_q == LAST) ? IDLE : RD;
        idx_d   = (idx_q == LAST) ? idx_q : idx_q + 8'h01;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 8'h00;
      src_q    <= 8'h00;
      reg_q    <= 8'h00;
      data_q   <= 8'h00;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      src_q    <= src_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
      issued_q <= issued_d;
    end
  end
  assign active    = state_q != IDLE;
  assign req_we    = state_q == WR;
  assign req_addr  = (state_q == WR) ? DST_BASE + {8'h00, idx_q} : {src_q, idx_q};
  assign req_wdata = (state_q == WR) ? wr_byte : 8'h00;
  assign reg_val   = reg_q;
endmodule

// File: rtl/gb_oam_dma.sv
// gb_oam_dma: main-bus arbiter between CPU and OAM DMA, high-port passthrough and FF46 register.
// GB_DMA_CPU_BLOCK_EN: defined blocks CPU main-bus access during DMA; undefined lets the CPU stall the DMA.
module gb_oam_dma #(
  parameter int          DMA_LEN  = 160,
  parameter logic [15:0] OAM_BASE = 16'hFE00
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] hi_addr,
  output logic [7:0]  hi_wdata,
  output logic        hi_rd,
  output logic        hi_wr,
  input  logic [7:0]  hi_rdata,
  output logic        dma_active
);
  import gb_bus_pkg::*;
  logic        is_hi, is_reg, cpu_main, cpu_bus, hold, start, req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, reg_val;
  rsel_t       rsel_q, rsel_d;
  assign is_hi    = cpu_addr[15:8] == HI_BASE[15:8];
  assign is_reg   = cpu_addr == DMA_REG_ADDR;
  assign start    = cpu_wr && is_reg;
  assign cpu_main = (cpu_rd || cpu_wr) && !is_hi;
`ifdef GB_DMA_CPU_BLOCK_EN
  assign hold    = 1'b0;
  assign cpu_bus = cpu_main && !dma_active;
`else
  assign hold    = cpu_main && dma_active;
  assign cpu_bus = cpu_main;
`endif
  dma_sequencer #(.DMA_LEN(DMA_LEN), .DST_BASE(OAM_BASE)) u_seq (
    .clk(Clk), .rst(reset), .start(start), .hold(hold),
    .wr_val(cpu_wdata), .mem_rdata(mem_rdata),
    .active(dma_active), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .reg_val(reg_val)
  );
  assign mem_addr  = cpu_bus ? cpu_addr : dma_active ? req_addr : 16'h0000;
  assign mem_we    = cpu_bus ? cpu_wr : dma_active && req_we;
  assign mem_wdata = cpu_bus ? (cpu_wr ? cpu_wdata : 8'h00) : dma_active ? req_wdata : 8'h00;
  assign hi_addr   = cpu_addr;
  assign hi_wdata  = cpu_wdata;
  assign hi_rd     = cpu_rd && is_hi && !is_reg;
  assign hi_wr     = cpu_wr && is_hi && !is_reg;
  // Blocked main-bus reads (and idle cycles) resolve to the open-bus value.
  assign rsel_d = !cpu_rd ? RSEL_BLOCK : is_reg ? RSEL_REG : is_hi ? RSEL_HI :
                  cpu_bus ? RSEL_MAIN : RSEL_BLOCK;
  always_ff @(posedge Clk) rsel_q <= reset ? RSEL_BLOCK : rsel_d;
  assign cpu_rdata = (rsel_q == RSEL_MAIN) ? mem_rdata :
                     (rsel_q == RSEL_HI)   ? hi_rdata  :
                     (rsel_q == RSEL_REG)  ? reg_val   : 8'hFF;
endmodule

// File: tb/tb_gb_oam_dma.sv
// tb_gb_oam_dma: directed scenario tasks for gb_oam_dma with a pattern ROM, OAM capture and high-port model.
module tb_gb_oam_dma;
  logic        Clk = 1'b0, reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [7:0]  cpu_rdata, mem_wdata, hi_wdata;
  logic [7:0]  mem_rdata = 8'h00, hi_rdata = 8'h00;
  logic [15:0] mem_addr, hi_addr;
  logic        mem_we, hi_rd, hi_wr, dma_active;
  logic [7:0]  oam [0:159];
  int          oam_wr_cnt = 0;
  int          tests = 0, fails = 0;

  gb_oam_dma dut (
    .Clk(Clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .hi_addr(hi_addr), .hi_wdata(hi_wdata), .hi_rd(hi_rd), .hi_wr(hi_wr),
    .hi_rdata(hi_rdata), .dma_active(dma_active)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] rom(input logic [15:0] a);
    case (a[15:8])
      8'hC1:   return a[7:0] ^ 8'h5A;
      8'hD0:   return a[7:0] ^ 8'hA5;
      8'hDE:   return a[7:0] ^ 8'h33;
      8'hC0:   return a[7:0] ^ 8'h77;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge Clk) begin
    mem_rdata <= rom(mem_addr);
    hi_rdata  <= (hi_addr == 16'hFF80) ? 8'h3C : 8'h00;
    if (mem_we && mem_addr >= 16'hFE00 && mem_addr < 16'hFEA0) begin
      oam[mem_addr[7:0]] <= mem_wdata;
      oam_wr_cnt <= oam_wr_cnt + 1;
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    tests += 7;
    if (dma_active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b want 0", dma_active); end
    if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    if (mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    if (mem_wdata !== 8'h00) begin fails++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
    if (hi_rd !== 1'b0) begin fails++; $display("FAIL reset_hi_rd: got %b want 0", hi_rd); end
    if (hi_wr !== 1'b0) begin fails++; $display("FAIL reset_hi_wr: got %b want 0", hi_wr); end
    if (cpu_rdata !== 8'hFF) begin fails++; $display("FAIL reset_cpu_rdata: got %h want FF", cpu_rdata); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_idle_bus;
    cpu_addr = 16'hC000; cpu_wdata = 8'h12; cpu_wr = 1'b1;
    #1;
    tests += 3;
    if (mem_we !== 1'b1) begin fails++; $display("FAIL idle_wr_we: got %b want 1", mem_we); end
    if (mem_addr !== 16'hC000) begin fails++; $display("FAIL idle_wr_addr: got %h want C000", mem_addr); end
    if (mem_wdata !== 8'h12) begin fails++; $display("FAIL idle_wr_data: got %h want 12", mem_wdata); end
    tick;
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    tick;
    cpu_rd = 1'b0; cpu_addr = 16'h0000;
    tests++;
    if (cpu_rdata !== 8'h77) begin fails++; $display("FAIL idle_rd_data: got %h want 77", cpu_rdata); end
  endtask

  task automatic test_hi;
    cpu_addr = 16'hFF80; cpu_rd = 1'b1;
    #1;
    tests++;
    if (hi_rd !== 1'b1 || hi_addr !== 16'hFF80) begin fails++; $display("FAIL hi_rd_strobe: got %b/%h want 1/FF80", hi_rd, hi_addr); end
    tick;
    cpu_rd = 1'b0; cpu_addr = 16'hFF47; cpu_wdata = 8'hE4; cpu_wr = 1'b1;
    tests += 2;
    if (cpu_rdata !== 8'h3C) begin fails++; $display("FAIL hi_rd_data: got %h want 3C", cpu_rdata); end
    #1;
    if (hi_wr !== 1'b1 || hi_wdata !== 8'hE4) begin fails++; $display("FAIL hi_wr_strobe: got %b/%h want 1/E4", hi_wr, hi_wdata); end
    tick;
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic test_dma_copy;
    int base, n, bad;
    base = oam_wr_cnt;
    cpu_addr = 16'hFF46; cpu_wdata = 8'hC1; cpu_wr = 1'b1;
    #1;
    tests += 2;
    if (hi_wr !== 1'b0) begin fails++; $display("FAIL ff46_hi_wr: got %b want 0", hi_wr); end
    if (dma_active !== 1'b0) begin fails++; $display("FAIL copy_pre_active: got %b want 0", dma_active); end
    tick;
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
    tests += 2;
    if (dma_active !== 1'b1) begin fails++; $display("FAIL copy_active: got %b want 1", dma_active); end
    if (mem_addr !== 16'hC100 || mem_we !== 1'b0) begin fails++; $display("FAIL copy_first_rd: got %h/%b want C100/0", mem_addr, mem_we); end
    n = 0;
    while (dma_active && n < 1000) begin tick; n++; end
    bad = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== (8'(i) ^ 8'h5A)) bad++;
    tests += 3;
    if (n !== 320) begin fails++; $display("FAIL copy_cycles: got %0d want 320", n); end
    if (bad !== 0) begin fails++; $display("FAIL copy_oam: got %0d bad bytes want 0", bad); end
    if (oam_wr_cnt - base !== 160) begin fails++; $display("FAIL copy_wr_count: got %0d want 160", oam_wr_cnt - base); end
  endtask

  task automatic test_src_map;
    int n, bad;
    cpu_addr = 16'hFF46; cpu_wdata = 8'hFE; cpu_wr = 1'b1;
    tick;
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    tests++;
    if (mem_addr !== 16'hDE00) begin fails++; $display("FAIL map_first_rd: got %h want DE00", mem_addr); end
    tick;
    cpu_rd = 1'b0; cpu_addr = 16'h0000;
    tests++;
    if (cpu_rdata !== 8'hFE) begin fails++; $display("FAIL map_readback: got %h want FE", cpu_rdata); end
    n = 0;
    while (dma_active && n < 1000) begin tick; n++; end
    bad = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== (8'(i) ^ 8'h33)) bad++;
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL map_oam: got %0d bad bytes want 0", bad); end
  endtask

  task automatic test_restart;
    int base, n, bad;
    base = oam_wr_cnt;
    cpu_addr = 16'hFF46; cpu_wdata = 8'hC1; cpu_wr = 1'b1;
    tick;
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
    n = 0;
    while (!(mem_we && mem_addr == 16'hFE32) && n < 500) begin tick; n++; end
    tests++;
    if (n >= 500) begin fails++; $display("FAIL restart_reach_idx50: got timeout want WR FE32"); end
    cpu_addr = 16'hFF46; cpu_wdata = 8'hD0; cpu_wr = 1'b1;
    #1;
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 16'hFE32 || mem_wdata !== 8'h68) begin
      fails++; $display("FAIL restart_inflight: got %b/%h/%h want 1/FE32/68", mem_we, mem_addr, mem_wdata);
    end
    tick;
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
    tests++;
    if (mem_addr !== 16'hD000 || mem_we !== 1'b0) begin fails++; $display("FAIL restart_rd: got %h/%b want D000/0", mem_addr, mem_we); end
    tick;
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 16'hFE00 || mem_wdata !== 8'hA5) begin
      fails++; $display("FAIL restart_wr: got %b/%h/%h want 1/FE00/A5", mem_we, mem_addr, mem_wdata);
    end
    cpu_addr = 16'hFF46; cpu_rd = 1'b1;
    tick;
    cpu_rd = 1'b0; cpu_addr = 16'h0000;
    tests++;
    if (cpu_rdata !== 8'hD0) begin fails++; $display("FAIL restart_readback: got %h want D0", cpu_rdata); end
    n = 0;
    while (dma_active && n < 1000) begin tick; n++; end
    bad = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== (8'(i) ^ 8'hA5)) bad++;
    tests += 2;
    if (bad !== 0) begin fails++; $display("FAIL restart_oam: got %0d bad bytes want 0", bad); end
    if (oam_wr_cnt - base !== 211) begin fails++; $display("FAIL restart_wr_count: got %0d want 211", oam_wr_cnt - base); end
  endtask

  task automatic test_reset_mid;
    int base, n, cnt;
    base = oam_wr_cnt;
    cpu_addr = 16'hFF46; cpu_wdata = 8'hC1; cpu_wr = 1'b1;
    tick;
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
    n = 0;
    while (!(mem_we && mem_addr == 16'hFE50) && n < 500) begin tick; n++; end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    cnt = oam_wr_cnt;
    tests += 4;
    if (dma_active !== 1'b0) begin fails++; $display("FAIL rstmid_active: got %b want 0", dma_active); end
    if (mem_we !== 1'b0) begin fails++; $display("FAIL rstmid_we: got %b want 0", mem_we); end
    if (mem_addr !== 16'h0000) begin fails++; $display("FAIL rstmid_addr: got %h want 0000", mem_addr); end
    if (cnt - base !== 81) begin fails++; $display("FAIL rstmid_wr_count: got %0d want 81", cnt - base); end
    for (int i = 0; i < 20; i++) tick;
    cpu_addr = 16'hFF46; cpu_rd = 1'b1;
    tick;
    cpu_rd = 1'b0; cpu_addr = 16'h0000;
    tests += 2;
    if (oam_wr_cnt !== cnt) begin fails++; $display("FAIL rstmid_no_more_wr: got %0d want %0d", oam_wr_cnt, cnt); end
    if (cpu_rdata !== 8'h00) begin fails++; $display("FAIL rstmid_reg: got %h want 00", cpu_rdata); end
  endtask

`ifdef GB_DMA_CPU_BLOCK_EN
  task automatic test_cpu_block;
    int n, bad;
    cpu_addr = 16'hFF46; cpu_wdata = 8'hC1; cpu_wr = 1'b1;
    tick;
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
    n = 0;
    while (dma_active && n < 1000) begin
      if (n == 10) begin
        cpu_addr = 16'hC000; cpu_rd = 1'b1;
        #1;
        tests++;
        if (mem_addr !== 16'hC105) begin fails++; $display("FAIL block_addr: got %h want C105", mem_addr); end
      end else if (n == 12) begin
        cpu_addr = 16'hC000; cpu_wdata = 8'h99; cpu_wr = 1'b1;
        #1;
        tests++;
        if (mem_we !== 1'b0) begin fails++; $display("FAIL block_wr_drop: got %b want 0", mem_we); end
      end else if (n == 20) begin
        cpu_addr = 16'hFF80; cpu_rd = 1'b1;
      end
      tick;
      cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000;
      if (n == 10) begin
        tests++;
        if (cpu_rdata !== 8'hFF) begin fails++; $display("FAIL block_rd: got %h want FF", cpu_rdata); end
      end
      if (n == 20) begin
        tests++;
        if (cpu_rdata !== 8'h3C) begin fails++; $display("FAIL block_hi_rd: got %h want 3C", cpu_rdata); end
      end
      n++;
    end
    bad = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== (8'(i) ^ 8'h5A)) bad++;
    tests += 2;
    if (n !== 320) begin fails++; $display("FAIL block_cycles: got %0d want 320", n); end
    if (bad !== 0) begin fails++; $display("FAIL block_oam: got %0d bad bytes want 0", bad); end
  endtask
`else
  task automatic test_cpu_contend;
    int base, n, bad;
    logic rd;
    base = oam_wr_cnt;
    cpu_addr = 16'hFF46; cpu_wdata = 8'hC1; cpu_wr = 1'b1;
    tick;
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
    n = 0;
    while (dma_active && n < 2000) begin
      rd = (n == 10) || (n == 52) || (n == 101) || (n == 200) || (n == 300);
      if (rd) begin
        cpu_addr = 16'hC000; cpu_rd = 1'b1;
        #1;
        if (n == 10) begin
          tests++;
          if (mem_addr !== 16'hC000 || mem_we !== 1'b0) begin fails++; $display("FAIL contend_bus: got %h/%b want C000/0", mem_addr, mem_we); end
        end
      end
      tick;
      cpu_rd = 1'b0; cpu_addr = 16'h0000;
      if (rd) begin
        tests++;
        if (cpu_rdata !== 8'h77) begin fails++; $display("FAIL contend_rd_%0d: got %h want 77", n, cpu_rdata); end
      end
      n++;
    end
    bad = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== (8'(i) ^ 8'h5A)) bad++;
    tests += 3;
    if (n !== 325) begin fails++; $display("FAIL contend_cycles: got %0d want 325", n); end
    if (bad !== 0) begin fails++; $display("FAIL contend_oam: got %0d bad bytes want 0", bad); end
    if (oam_wr_cnt - base !== 160) begin fails++; $display("FAIL contend_wr_count: got %0d want 160", oam_wr_cnt - base); end
  endtask
`endif

  initial begin
    test_reset;
    test_idle_bus;
    test_hi;
    test_dma_copy;
    test_src_map;
    test_restart;
    test_reset_mid;
`ifdef GB_DMA_CPU_BLOCK_EN
    test_cpu_block;
`else
    test_cpu_contend;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
